branch_resolve_unit: RTL and testbench

- Back end of the branch prediction loop. Records each prediction issued at fetch in an in-order tracking queue.
- Matches each queued prediction against the execute-stage outcome, in program order.
- Drives the predictor training interface (update, branchPC, resultPC, taken) and raises mispredict/redirect toward fetch.
- On a misprediction, flushes all younger wrong-path entries.

---
 rtl/branch_resolve_unit.sv | 167 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of fetch predictions, matched against execute outcomes to train the predictor and redirect fetch.
// Optional macro BRU_PERF_CNT_EN adds branch/miss performance counters.
module branch_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             res_ready,
  output logic             update,
  output logic [31:0]      branchPC,
  output logic [31:0]      resultPC,
  output logic             taken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] count
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_misses
`endif
);

  // state    | meaning
  // ST_NORMAL| accept pushes and resolves
  // ST_FLUSH | one-cycle redirect after a miss; queue frozen
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {ST_NORMAL, ST_FLUSH} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_pc     [DEPTH];
  logic [31:0]      r_target [DEPTH];
  logic [DEPTH-1:0] r_taken;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic        r_update;
  logic [31:0] r_branch_pc;
  logic [31:0] r_result_pc;
  logic        r_taken_o;
  logic        r_mispredict;
  logic [31:0] r_redirect_pc;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_head_pc;
  logic [31:0] w_head_target;
  logic        w_head_taken;
  logic [31:0] w_actual_pc;
  logic        w_miss;
  logic        w_flush;

  assign w_full        = (r_count == CNT_W'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign pred_ready    = (r_state == ST_NORMAL) && !w_full;
  assign res_ready     = (r_state == ST_NORMAL) && !w_empty;
  assign w_push        = pred_valid && pred_ready;
  assign w_pop         = res_valid && res_ready;
  assign w_head_pc     = r_pc[r_head];
  assign w_head_target = r_target[r_head];
  assign w_head_taken  = r_taken[r_head];
  assign w_actual_pc   = res_taken ? res_target : (w_head_pc + 32'd4);
  // A not-taken branch that was predicted not-taken is a hit whatever the targets say.
  assign w_miss        = (w_head_taken != res_taken) ||
                         (res_taken && (w_head_target != res_target));
  assign w_flush       = w_pop && w_miss;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_NORMAL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: if (w_flush) w_state_nxt = ST_FLUSH;
      ST_FLUSH:  w_state_nxt = ST_NORMAL;
      default:   w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail]     <= pred_pc;
      r_target[r_tail] <= pred_target;
      r_taken[r_tail]  <= pred_taken;
    end
  end

  // A miss discards everything younger, including a push in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_update      <= 1'b0;
      r_branch_pc   <= '0;
      r_result_pc   <= '0;
      r_taken_o     <= 1'b0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_update     <= w_pop;
      r_mispredict <= w_flush;
      if (w_pop) begin
        r_branch_pc <= w_head_pc;
        r_result_pc <= w_actual_pc;
        r_taken_o   <= res_taken;
      end
      if (w_flush) r_redirect_pc <= w_actual_pc;
    end
  end

  assign update      = r_update;
  assign branchPC    = r_branch_pc;
  assign resultPC    = r_result_pc;
  assign taken       = r_taken_o;
  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirect_pc;
  assign count       = r_count;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_misses;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_branches <= '0;
      r_perf_misses   <= '0;
    end else begin
      if (w_pop)   r_perf_branches <= r_perf_branches + 32'd1;
      if (w_flush) r_perf_misses   <= r_perf_misses + 32'd1;
    end
  end

  assign perf_branches = r_perf_branches;
  assign perf_misses   = r_perf_misses;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus hand sequences, training outputs checked through a scoreboard.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_ready;
  logic        update;
  logic [31:0] branchPC;
  logic [31:0] resultPC;
  logic        taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  count;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_misses;
`endif

  branch_resolve_unit #(.DEPTH(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid  (pred_valid),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_ready  (pred_ready),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .res_ready   (res_ready),
    .update      (update),
    .branchPC    (branchPC),
    .resultPC    (resultPC),
    .taken       (taken),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc),
    .count       (count)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches (perf_branches),
    .perf_misses   (perf_misses)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic        taken;
    logic        miss;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        rt;
    logic [31:0] rtgt;
    logic [31:0] exp_res;
    logic        exp_miss;
  } vec_t;

  int    n_pass  = 0;
  int    n_total = 0;
  int    n_br    = 0;
  int    n_miss  = 0;
  pred_t mq[$];
  exp_t  sbq[$];
  vec_t  vecs[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input pred_t p, input logic rt, input logic [31:0] rtgt);
    exp_t e;
    e.pc    = p.pc;
    e.taken = rt;
    e.res   = rt ? rtgt : p.pc + 32'd4;
    e.miss  = (p.taken != rt) || (rt && (p.target != rtgt));
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (update) begin
        if (sbq.size() == 0) begin
          check("unexpected_update", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("branchPC", branchPC, e.pc);
          check("resultPC", resultPC, e.res);
          check("taken", {31'd0, taken}, {31'd0, e.taken});
          check("mispredict", {31'd0, mispredict}, {31'd0, e.miss});
          if (e.miss) check("redirect_pc", redirect_pc, e.res);
        end
      end else if (mispredict) begin
        check("mispredict_without_update", 32'd1, 32'd0);
      end
    end
  end

  task automatic push_pred(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_taken  = pt;
    pred_target = tgt;
    mq.push_back('{pc, pt, tgt});
    step();
    pred_valid = 1'b0;
  endtask

  // Resolves the model head; on a miss also steps through the flush cycle.
  task automatic resolve(input logic rt, input logic [31:0] rtgt);
    exp_t e;
    e = model(mq.pop_front(), rt, rtgt);
    sbq.push_back(e);
    n_br++;
    if (e.miss) begin
      n_miss++;
      mq.delete();
    end
    res_valid  = 1'b1;
    res_taken  = rt;
    res_target = rtgt;
    step();
    res_valid = 1'b0;
    check("resolve_update", {31'd0, update}, 32'd1);
    if (e.miss) step();
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;

    vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200, 32'h0000_0200, 1'b0};
    vecs[1] = '{32'h0000_0300, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0000, 32'h0000_0304, 1'b1};
    vecs[2] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_0400, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0404, 1'b0};
    vecs[4] = '{32'h0000_0500, 1'b1, 32'h0000_0600, 1'b1, 32'h0000_0700, 32'h0000_0700, 1'b1};
    vecs[5] = '{32'h0000_0600, 1'b0, 32'h0000_0999, 1'b1, 32'h0000_0800, 32'h0000_0800, 1'b1};
    vecs[6] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h0000_0700, 1'b0, 32'h0000_0123, 1'b0, 32'h0000_0456, 32'h0000_0704, 1'b0};

    repeat (2) step();
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_update", {31'd0, update}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_branchPC", branchPC, 32'd0);
    check("rst_resultPC", resultPC, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_res_ready", {31'd0, res_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_pred_ready", {31'd0, pred_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      pred_valid  = 1'b1;
      pred_pc     = vecs[i].pc;
      pred_taken  = vecs[i].pt;
      pred_target = vecs[i].ptgt;
      step();
      pred_valid = 1'b0;
      check("vec_push_count", {28'd0, count}, 32'd1);
      check("vec_res_ready", {31'd0, res_ready}, 32'd1);
      res_valid  = 1'b1;
      res_taken  = vecs[i].rt;
      res_target = vecs[i].rtgt;
      sbq.push_back('{vecs[i].pc, vecs[i].exp_res, vecs[i].rt, vecs[i].exp_miss});
      n_br++;
      if (vecs[i].exp_miss) n_miss++;
      step();
      res_valid = 1'b0;
      check("vec_update", {31'd0, update}, 32'd1);
      check("vec_pop_count", {28'd0, count}, 32'd0);
      check("vec_pred_ready", {31'd0, pred_ready}, {31'd0, !vecs[i].exp_miss});
      step();
      check("vec_after_mispredict", {31'd0, mispredict}, 32'd0);
      check("vec_after_update", {31'd0, update}, 32'd0);
      check("vec_after_pred_ready", {31'd0, pred_ready}, 32'd1);
    end

    // Miss flushes older-than-nothing queue contents and a same-cycle push.
    push_pred(32'h100, 1'b0, 32'h0);
    push_pred(32'h110, 1'b0, 32'h0);
    push_pred(32'h120, 1'b0, 32'h0);
    check("seqA_count3", {28'd0, count}, 32'd3);
    pred_valid = 1'b1; pred_pc = 32'h130; pred_taken = 1'b0; pred_target = 32'h0;
    res_valid  = 1'b1; res_taken = 1'b1; res_target = 32'h400;
    e = model(mq.pop_front(), 1'b1, 32'h400);
    sbq.push_back(e);
    n_br++; n_miss++;
    mq.delete();
    step();
    pred_valid = 1'b0; res_valid = 1'b0;
    check("seqA_flush_count", {28'd0, count}, 32'd0);
    check("seqA_mispredict", {31'd0, mispredict}, 32'd1);
    check("seqA_redirect", redirect_pc, 32'h400);
    check("seqA_pred_ready", {31'd0, pred_ready}, 32'd0);
    check("seqA_res_ready", {31'd0, res_ready}, 32'd0);
    step();
    check("seqA_back_normal", {31'd0, mispredict}, 32'd0);
    check("seqA_pred_ready2", {31'd0, pred_ready}, 32'd1);
    push_pred(32'h200, 1'b0, 32'h0);
    check("seqA_post_count", {28'd0, count}, 32'd1);
    resolve(1'b0, 32'h0);

    // Fill, refused push on full with a concurrent pop, then drain across the wrap.
    for (int i = 0; i < 8; i++) push_pred(32'h1000 + 32'(i * 16), 1'b0, 32'h0);
    check("full_count", {28'd0, count}, 32'd8);
    check("full_pred_ready", {31'd0, pred_ready}, 32'd0);
    pred_valid = 1'b1; pred_pc = 32'hDEAD_0000; pred_taken = 1'b0; pred_target = 32'h0;
    res_valid  = 1'b1; res_taken = 1'b0; res_target = 32'h0;
    sbq.push_back(model(mq.pop_front(), 1'b0, 32'h0));
    n_br++;
    step();
    pred_valid = 1'b0; res_valid = 1'b0;
    check("refused_count", {28'd0, count}, 32'd7);
    pred_valid = 1'b1; pred_pc = 32'h2000; pred_taken = 1'b0; pred_target = 32'h0;
    res_valid  = 1'b1; res_taken = 1'b0; res_target = 32'h0;
    sbq.push_back(model(mq.pop_front(), 1'b0, 32'h0));
    mq.push_back('{32'h2000, 1'b0, 32'h0});
    n_br++;
    step();
    pred_valid = 1'b0; res_valid = 1'b0;
    check("pushpop_count", {28'd0, count}, 32'd7);
    while (mq.size() > 0) resolve(1'b0, 32'h0);
    check("drain_count", {28'd0, count}, 32'd0);

    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h1234;
    step();
    res_valid = 1'b0;
    check("empty_res_update", {31'd0, update}, 32'd0);
    check("empty_res_count", {28'd0, count}, 32'd0);

    for (int i = 0; i < 5; i++) push_pred(32'h3000 + 32'(i * 4), 1'b0, 32'h0);
    check("pre_rst_count", {28'd0, count}, 32'd5);
`ifdef BRU_PERF_CNT_EN
    check("perf_branches", perf_branches, 32'(n_br));
    check("perf_misses", perf_misses, 32'(n_miss));
`endif
    rst = 1'b1; res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0;
    step();
    rst = 1'b0; res_valid = 1'b0;
    mq.delete();
    check("mid_rst_count", {28'd0, count}, 32'd0);
    check("mid_rst_update", {31'd0, update}, 32'd0);
    check("mid_rst_mispredict", {31'd0, mispredict}, 32'd0);
`ifdef BRU_PERF_CNT_EN
    check("mid_rst_perf_branches", perf_branches, 32'd0);
    check("mid_rst_perf_misses", perf_misses, 32'd0);
`endif
    step();
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
